// File: rtl/pulse_period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_period_meter_pkg
//  Description : Shared types and helpers for the pulse period meter: the
//                measurement state encoding and a saturating increment used
//                by the high and low cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_period_meter_pkg;

    // Measurement phase of the incoming square wave
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meter_state_t;

    // Counters up to 32 bits wide are passed through this helper zero-extended.
    // The value sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_period_meter_edge_sync_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync_detect
//  Description : Synchronises an asynchronous level through SYNC_STAGES flops,
//                keeps one extra delayed copy and reports single-cycle rise
//                and fall strobes on the synchronised level.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_d_q;
    logic                   s_d_d;

    // Shift the raw input down the synchroniser chain; remember the last output
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s_d_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay flops, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

endmodule
`default_nettype wire

// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_period_meter
//  Description : Measures high time, low time and period of a square wave in
//                clk cycles, one result per rising-to-rising period, offered
//                on a single-slot valid/ready port. Flags dropped results,
//                clamped counts and a stopped input.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pulse_in,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic [CNT_WIDTH-1:0] low_cycles,
    output logic [CNT_WIDTH:0]   period_cycles,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 overrun,
    output logic                 saturated,
    output logic                 stalled
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   TIMEOUT_LIM = (CNT_WIDTH+1)'(TIMEOUT);

    logic s;
    logic rise;
    logic fall;

    edge_sync_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync_detect (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    meter_state_t         state_q,   state_d;
    logic [CNT_WIDTH-1:0] hcnt_q,    hcnt_d;
    logic [CNT_WIDTH-1:0] lcnt_q,    lcnt_d;
    logic [CNT_WIDTH-1:0] idle_q,    idle_d;
    logic                 stalled_q, stalled_d;
    logic [CNT_WIDTH-1:0] res_high_q, res_high_d;
    logic [CNT_WIDTH-1:0] res_low_q,  res_low_d;
    logic [CNT_WIDTH:0]   res_per_q,  res_per_d;
    logic                 res_sat_q,  res_sat_d;
    logic                 valid_q,    valid_d;
    logic                 overrun_q,  overrun_d;

    logic                 publish;
    logic                 timeout_hit;

    // The idle count would reach TIMEOUT on this cycle if no edge arrives
    assign timeout_hit = ({1'b0, idle_q} + {{CNT_WIDTH{1'b0}}, 1'b1}) >= TIMEOUT_LIM;

    // Next-state, counters and the publish strobe; an edge outranks a timeout
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        lcnt_d    = lcnt_q;
        idle_d    = idle_q;
        stalled_d = stalled_q;
        publish   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_HIGH;
                        hcnt_d    = CNT_ONE;
                        lcnt_d    = '0;
                        idle_d    = '0;
                        stalled_d = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d = ST_LOW;
                        lcnt_d  = CNT_ONE;
                        idle_d  = '0;
                    end else if (timeout_hit) begin
                        state_d   = ST_IDLE;
                        hcnt_d    = '0;
                        lcnt_d    = '0;
                        idle_d    = '0;
                        stalled_d = 1'b1;
                    end else begin
                        idle_d = idle_q + CNT_ONE;
                        if (s) begin
                            hcnt_d = CNT_WIDTH'(sat_inc(32'(hcnt_q), 32'(CNT_MAX)));
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        publish   = 1'b1;
                        state_d   = ST_HIGH;
                        hcnt_d    = CNT_ONE;
                        lcnt_d    = '0;
                        idle_d    = '0;
                        stalled_d = 1'b0;
                    end else if (timeout_hit) begin
                        state_d   = ST_IDLE;
                        hcnt_d    = '0;
                        lcnt_d    = '0;
                        idle_d    = '0;
                        stalled_d = 1'b1;
                    end else begin
                        idle_d = idle_q + CNT_ONE;
                        if (!s) begin
                            lcnt_d = CNT_WIDTH'(sat_inc(32'(lcnt_q), 32'(CNT_MAX)));
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Single result slot: load when free (or freed this cycle), else drop and flag
    always_comb begin
        res_high_d = res_high_q;
        res_low_d  = res_low_q;
        res_per_d  = res_per_q;
        res_sat_d  = res_sat_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (publish && (!valid_q || result_ready)) begin
            res_high_d = hcnt_q;
            res_low_d  = lcnt_q;
            res_per_d  = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            res_sat_d  = (hcnt_q == CNT_MAX) || (lcnt_q == CNT_MAX);
            valid_d    = 1'b1;
        end else if (publish) begin
            overrun_d = 1'b1;
        end else if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
    end

    // All measurement and result state, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            idle_q     <= '0;
            stalled_q  <= 1'b0;
            res_high_q <= '0;
            res_low_q  <= '0;
            res_per_q  <= '0;
            res_sat_q  <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            idle_q     <= idle_d;
            stalled_q  <= stalled_d;
            res_high_q <= res_high_d;
            res_low_q  <= res_low_d;
            res_per_q  <= res_per_d;
            res_sat_q  <= res_sat_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign high_cycles   = res_high_q;
    assign low_cycles    = res_low_q;
    assign period_cycles = res_per_q;
    assign result_valid  = valid_q;
    assign overrun       = overrun_q;
    assign saturated     = res_sat_q;
    assign stalled       = stalled_q;

endmodule
`default_nettype wire

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Downstream consumer of the timer block's pulse output. It measures the high time, low time and period of the square wave in clk cycles, one result per complete rising-to-rising period. Each result is presented on a valid/ready output port for a display or logging stage. The block also flags dropped results, saturated counts and a stopped oscillator.

Parameters:
CNT_WIDTH, 16, width of the high and low cycle counters.
SYNC_STAGES, 2, flip-flop stages that synchronise pulse_in; legal values are 1 or more.
TIMEOUT, 65535, cycles without an edge before the measurement is abandoned; legal range is 1 to 2^CNT_WIDTH-1.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
enable  in  1  1 = measure; 0 = return to IDLE and hold outputs.
pulse_in  in  1  square wave from the timer stage; treated as asynchronous.
high_cycles  out  CNT_WIDTH  captured high duration.
low_cycles  out  CNT_WIDTH  captured low duration.
period_cycles  out  CNT_WIDTH+1  high_cycles + low_cycles, full width, never wraps.
result_valid  out  1  result registers hold an unconsumed result.
result_ready  in  1  consumer accepts the result when valid and ready are both 1.
overrun  out  1  sticky; a completed result was dropped because the slot was full.
saturated  out  1  the current result has at least one counter clamped at all-ones.
stalled  out  1  timeout occurred; no period is being measured.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, synchroniser flops 0, state = IDLE, internal counters 0.
  - Reset deasserted mid-period: measurement restarts from IDLE; no partial result is ever emitted.
- Synchroniser: s = pulse_in delayed SYNC_STAGES cycles; s_d = s delayed one more cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- States: IDLE, HIGH, LOW.
  - IDLE --rise--> HIGH. Load hcnt=1, lcnt=0. Nothing is published on this first edge.
  - HIGH: each cycle s=1, hcnt saturating-increments (holds at 2^CNT_WIDTH-1).
  - HIGH --fall--> LOW. Load lcnt=1.
  - LOW: each cycle s=0, lcnt saturating-increments.
  - LOW --rise--> HIGH. The period is complete: publish hcnt/lcnt, then load hcnt=1, lcnt=0.
  - A rise seen while in HIGH, or a fall seen while in LOW, cannot occur.
- Publish:
  - Slot free (result_valid=0, or result_valid=1 with result_ready=1 in the same cycle):
    - register high_cycles, low_cycles, period_cycles and saturated.
    - result_valid=1 on the next cycle. Latency from the pulse_in edge to result_valid is SYNC_STAGES+2 cycles.
  - Slot full: the new result is discarded, old data is held unchanged, and overrun is set.
  - overrun clears only on reset.
- Handshake:
  - result_valid falls on the cycle after valid&ready, unless a publish happens in that same cycle.
  - Outputs are stable while valid=1 and ready=0.
- Timeout:
  - An idle counter resets on every rise or fall. If it reaches TIMEOUT in HIGH or LOW, the state goes to IDLE and stalled=1.
  - stalled clears on the next rise.
  - The partial period is discarded; any pending result stays valid.
- enable=0: state goes to IDLE the next cycle and counters are cleared. Pending result, overrun and stalled hold their values.
- An edge and a timeout in the same cycle: the edge wins.

Decomposition:
- Shared timer package holds:
  - the state enum typedef (IDLE, HIGH, LOW);
  - a saturating-increment function used by both counters.
- One sub-module, edge_sync_detect. It contains the SYNC_STAGES synchroniser and the s_d flop, and outputs s, rise and fall.
- The FSM, counters and output slot stay in the top module.

Test Plan:
1. Reset, then drive 5 cycles high / 3 cycles low repeatedly with ready=1.
   - First result: high=5, low=3, period=8, valid asserted SYNC_STAGES+2 cycles after the 2nd rising edge.
   - Results repeat every 8 cycles.
2. ready=0 across 3 periods.
   - The first result is held with valid=1; overrun=1 after the 2nd completed period.
   - Raising ready consumes that first result; valid drops.
3. CNT_WIDTH=4, high for 20 cycles then low for 2.
   - high=15, low=2, period=17, saturated=1.
4. TIMEOUT=10, pulse_in held high after a rise.
   - stalled=1 ten cycles after the last edge and state=IDLE.
   - The next rise clears stalled; no result is emitted until a further complete period.
5. Assert reset mid-LOW, then release.
   - All outputs are 0 immediately, asynchronously.
   - The first result after release needs two rising edges.
6. enable=0 for 4 cycles mid-HIGH, then enable=1.
   - The first published result covers only a period that started after re-enable. No combined stale counts appear.
